// File: rtl/spi_core_pkg.sv
// Shared types and constants for the SPI master core.
// The SPI_CORE_CONT_EN macro (used in spi_core.sv) enables continuous back-to-back words.
package spi_core_pkg;
  localparam int DIV_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // A divider setting of zero behaves like one.
  function automatic logic [DIV_W-1:0] div_max1(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// Toggle-event pulse generator: while i_run is high, o_tick fires once every i_div clocks.
module spi_clk_gen
  import spi_core_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == i_div - 1'b1);
  assign o_tick = i_run & w_last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              r_cnt <= '0;
    else if (!i_run || w_last) r_cnt <= '0;
    else                       r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/spi_core.sv
// SPI master, one active select, MSB first, all four CPOL/CPHA modes.
// Macro SPI_CORE_CONT_EN enables the continuous (back-to-back word) mode driven by cont.
module spi_core
  import spi_core_pkg::*;
#(
  parameter int SLAVES  = 1,
  parameter int D_WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cpol,
  input  logic               cpha,
  input  logic               cont,
  input  logic [DIV_W-1:0]   clk_div,
  input  logic [D_WIDTH-1:0] tx_data,
  input  logic               miso,
  output logic               sclk,
  output logic [SLAVES-1:0]  ss_n,
  output logic               mosi,
  output logic               busy,
  output logic [D_WIDTH-1:0] rx_data
);
  localparam int            EW       = $clog2(2*D_WIDTH+2);
  localparam logic [EW-1:0] LAST_EVT = EW'(2*D_WIDTH);

  state_t             r_state, w_next;
  logic               r_hold, r_cpol, r_cpha, r_sclk, r_mosi;
  logic [DIV_W-1:0]   r_div;
  logic [D_WIDTH-1:0] r_tx, r_rx, r_rxd;
  logic [EW-1:0]      r_evt, w_evt_n;
  logic               w_tick, w_start, w_end, w_tgl, w_busy, w_ss0_n, w_cont;

`ifdef SPI_CORE_CONT_EN
  assign w_cont = cont;
`else
  assign w_cont = cont & 1'b0;
`endif

  spi_clk_gen u_clk_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .i_run   (r_state == XFER),
    .i_div   (r_div),
    .o_tick  (w_tick)
  );

  // r_hold keeps the select asserted across the one-clock gap of a word reload.
  assign w_start = (r_state == IDLE) && (enable || r_hold);
  assign w_evt_n = r_evt + 1'b1;
  assign w_end   = (r_state == XFER) && w_tick && (r_evt == LAST_EVT);
  assign w_tgl   = (r_state == XFER) && w_tick && !w_end;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = XFER;
      XFER:    if (w_end)   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (r_state == XFER);
    w_ss0_n = !(w_busy || r_hold);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold <= 1'b0;
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_div  <= DIV_W'(1);
      r_evt  <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_rxd  <= '0;
    end else if (w_start) begin
      r_cpol <= cpol;
      r_cpha <= cpha;
      r_div  <= div_max1(clk_div);
      r_evt  <= '0;
      r_hold <= 1'b0;
      r_sclk <= cpol;
      if (!cpha) begin
        r_mosi <= tx_data[D_WIDTH-1];
        r_tx   <= {tx_data[D_WIDTH-2:0], 1'b0};
      end else begin
        r_mosi <= 1'b0;
        r_tx   <= tx_data;
      end
    end else if (r_state == IDLE) begin
      r_sclk <= cpol;
      r_mosi <= 1'b0;
    end else if (w_end) begin
      r_rxd  <= r_rx;
      r_hold <= w_cont;
      r_sclk <= r_cpol;
    end else if (w_tgl) begin
      r_evt  <= w_evt_n;
      r_sclk <= ~r_sclk;
      // cpha=0 captures on odd events, cpha=1 on even ones.
      if (w_evt_n[0] ^ r_cpha) begin
        r_rx <= {r_rx[D_WIDTH-2:0], miso};
      end else begin
        r_mosi <= r_tx[D_WIDTH-1];
        r_tx   <= {r_tx[D_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    ss_n    = '1;
    ss_n[0] = w_ss0_n;
  end

  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign busy    = w_busy;
  assign rx_data = r_rxd;
endmodule

// File: tb/tb_spi_core.sv
// Directed bench for spi_core: modes, timing, reset abort, held enable and continuous words.
module tb_spi_core;
  logic       clock, reset_n, enable, cpol, cpha, cont, miso, sclk, mosi, busy;
  logic [7:0] clk_div, tx_data, rx_data;
  logic [1:0] ss_n;
  logic       loop, miso_k;
  int         n_tests, n_fail;

  assign miso = loop ? mosi : miso_k;

  spi_core #(.SLAVES(2), .D_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cpol(cpol), .cpha(cpha),
    .cont(cont), .clk_div(clk_div), .tx_data(tx_data), .miso(miso), .sclk(sclk),
    .ss_n(ss_n), .mosi(mosi), .busy(busy), .rx_data(rx_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, output bit ok);
    int k = 0;
    while (busy !== lvl && k < 500) begin
      @(negedge clock);
      k++;
    end
    ok = (busy === lvl);
  endtask

  // One word; inputs are disturbed right after the start to show they are latched.
  task automatic xfer(input logic p, input logic h, input logic [7:0] div, input logic [7:0] tx,
                      output int bcyc, output int rises, output logic [7:0] mbits, output bit ss_ok);
    logic prev;
    @(negedge clock);
    cpol = p; cpha = h; clk_div = div; tx_data = tx; enable = 1'b1;
    @(negedge clock);
    enable = 1'b0; tx_data = ~tx; clk_div = 8'd7;
    bcyc = 0; rises = 0; mbits = '0; ss_ok = 1'b1; prev = sclk;
    while (busy === 1'b1 && bcyc < 2000) begin
      bcyc++;
      if (ss_n !== 2'b10) ss_ok = 1'b0;
      @(negedge clock);
      if (sclk !== prev) begin
        if (sclk) rises++;
        if (sclk == (h ? p : ~p)) mbits = {mbits[6:0], mosi};
        prev = sclk;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bc, rs;
    logic [7:0] mb;
    bit         ok, sok;
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; enable = 1'b0; cpol = 1'b1; cpha = 1'b0; cont = 1'b0;
    clk_div = 8'd2; tx_data = 8'h00; loop = 1'b1; miso_k = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ss_n", ss_n, 2'b11);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rx",   rx_data, 0);
    @(negedge clock); @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_sclk_cpol1", sclk, 1);
    cpol = 1'b0;
    @(negedge clock);
    chk("idle_sclk_cpol0", sclk, 0);

    // mode 0, divider 2, loopback
    xfer(1'b0, 1'b0, 8'd2, 8'hA5, bc, rs, mb, sok);
    chk("m0_busy_cyc", bc, 34);
    chk("m0_rises", rs, 8);
    chk("m0_mosi", mb, 8'hA5);
    chk("m0_ss_low", sok, 1);
    chk("m0_rx", rx_data, 8'hA5);
    chk("m0_ss_idle", ss_n, 2'b11);
    chk("m0_mosi_idle", mosi, 0);

    // mode 3, divider 0 (acts as 1), miso tied high
    loop = 1'b0; miso_k = 1'b1;
    @(negedge clock); cpol = 1'b1;
    @(negedge clock);
    chk("m3_sclk_idle", sclk, 1);
    xfer(1'b1, 1'b1, 8'd0, 8'h3C, bc, rs, mb, sok);
    chk("m3_busy_cyc", bc, 17);
    chk("m3_rises", rs, 8);
    chk("m3_mosi", mb, 8'h3C);
    chk("m3_rx", rx_data, 8'hFF);
    chk("m3_sclk_end", sclk, 1);

    // mode 1, divider 3, loopback
    loop = 1'b1;
    xfer(1'b0, 1'b1, 8'd3, 8'h96, bc, rs, mb, sok);
    chk("m1_busy_cyc", bc, 51);
    chk("m1_mosi", mb, 8'h96);
    chk("m1_rx", rx_data, 8'h96);
    tx_data = 8'h00;
    repeat (5) @(negedge clock);
    chk("rx_hold", rx_data, 8'h96);

    // reset in the middle of a word
    cpol = 1'b0; cpha = 1'b0; clk_div = 8'd2; tx_data = 8'h5A; enable = 1'b1;
    @(negedge clock); enable = 1'b0;
    repeat (10) @(negedge clock);
    chk("abort_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_ss_n", ss_n, 2'b11);
    chk("abort_busy", busy, 0);
    chk("abort_rx", rx_data, 0);
    @(negedge clock); reset_n = 1'b1;
    xfer(1'b0, 1'b0, 8'd2, 8'h5A, bc, rs, mb, sok);
    chk("after_abort_busy_cyc", bc, 34);
    chk("after_abort_rx", rx_data, 8'h5A);

    // enable held high, cont low: words repeat with a deselect gap
    @(negedge clock);
    cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; tx_data = 8'h11; enable = 1'b1;
    wait_busy(1'b1, ok); chk("hold_start", ok, 1);
    wait_busy(1'b0, ok); chk("hold_end1", ok, 1);
    chk("hold_gap_ss_n", ss_n, 2'b11);
    chk("hold_rx1", rx_data, 8'h11);
    tx_data = 8'hC3;
    @(negedge clock);
    chk("hold_restart", busy, 1);
    enable = 1'b0;
    wait_busy(1'b0, ok); chk("hold_end2", ok, 1);
    chk("hold_rx2", rx_data, 8'hC3);

`ifdef SPI_CORE_CONT_EN
    @(negedge clock);
    cpha = 1'b0; clk_div = 8'd1; tx_data = 8'h12; cont = 1'b1; enable = 1'b1;
    @(negedge clock); enable = 1'b0;
    sok = 1'b1; bc = 0;
    while (busy === 1'b1 && bc < 500) begin
      if (ss_n[0] !== 1'b0) sok = 1'b0;
      @(negedge clock); bc++;
    end
    chk("cont_gap_ss0", ss_n[0], 0);
    chk("cont_rx1", rx_data, 8'h12);
    tx_data = 8'h34; cont = 1'b0;
    @(negedge clock);
    chk("cont_busy_gap_one", busy, 1);
    bc = 0;
    while (busy === 1'b1 && bc < 500) begin
      if (ss_n[0] !== 1'b0) sok = 1'b0;
      @(negedge clock); bc++;
    end
    chk("cont_w2_cyc", bc, 17);
    chk("cont_ss_low", sok, 1);
    chk("cont_rx2", rx_data, 8'h34);
    chk("cont_ss_end", ss_n, 2'b11);
`else
    @(negedge clock);
    cpha = 1'b0; clk_div = 8'd1; tx_data = 8'h12; cont = 1'b1; enable = 1'b1;
    @(negedge clock); enable = 1'b0;
    wait_busy(1'b0, ok); chk("nocont_end", ok, 1);
    chk("nocont_ss_n", ss_n, 2'b11);
    chk("nocont_rx", rx_data, 8'h12);
    @(negedge clock);
    chk("nocont_idle1", busy, 0);
    @(negedge clock);
    chk("nocont_idle2", busy, 0);
    cont = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_core.md
SPI_CORE -- requirements
Module: spi_core

Interface
REQ-001 SHALL have parameter SLAVES, default 1: number of slave-select lines.
REQ-002 SHALL have parameter D_WIDTH, default 8: bits per transfer word.
REQ-003 SHALL have port clock, input, 1: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1: start request, sampled while idle.
REQ-006 SHALL have port cpol, input, 1: SCLK idle level.
REQ-007 SHALL have port cpha, input, 1: 0 = capture on leading edge, 1 = capture on trailing edge.
REQ-008 SHALL have port cont, input, 1: continuous (back-to-back word) request.
REQ-009 SHALL have port clk_div, input, 8: SCLK half-period in clocks; 0 treated as 1.
REQ-010 SHALL have port tx_data, input, D_WIDTH: word to send, MSB first.
REQ-011 SHALL have port miso, input, 1: serial data from slave.
REQ-012 SHALL have port sclk, output, 1: SPI clock.
REQ-013 SHALL have port ss_n, output, SLAVES: active-low selects; only ss_n[0] is driven active, others constant 1.
REQ-014 SHALL have port mosi, output, 1: serial data to slave.
REQ-015 SHALL have port busy, output, 1: transfer in progress.
REQ-016 SHALL have port rx_data, output, D_WIDTH: last received word.

Function
REQ-017 SHALL implement two states: IDLE and XFER.
REQ-018 In IDLE: busy=0, ss_n all 1, sclk=cpol, mosi idle level; enable=1 sampled at a clock edge SHALL latch tx_data, cpol, cpha, divider N=max(clk_div,1), set ss_n[0]=0, busy=1, enter XFER.
REQ-019 In XFER a toggle event SHALL occur every N clocks; sclk SHALL toggle on the first 2*D_WIDTH events, then stay at cpol.
REQ-020 cpha=0: mosi SHALL present tx MSB on entering XFER; odd toggles capture miso, even toggles shift out next bit.
REQ-021 cpha=1: odd toggles shift out the next bit (first one MSB), even toggles capture miso.
REQ-022 Transfer SHALL end on event 2*D_WIDTH+1, so busy stays high for exactly (2*D_WIDTH+1)*N clocks.
REQ-023 At end with cont=0: rx_data SHALL update to the captured word (MSB first received = rx_data[D_WIDTH-1]), ss_n all 1, busy=0, return to IDLE.
REQ-024 At end with cont=1: rx_data SHALL update, current tx_data reloaded, ss_n[0] stays 0, busy low for exactly one clock, then next word starts with the same timing.
REQ-025 enable, tx_data, cpol, cpha, clk_div changes during XFER SHALL be ignored until the next start or word reload.
REQ-026 rx_data SHALL hold its value between transfers.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE, busy=0, ss_n all 1, sclk=0, mosi idle level, rx_data=0, aborting any transfer without updating rx_data.
REQ-028 After reset release, sclk SHALL follow cpol from the first clock edge.

Configuration
REQ-029 Macro SPI_CORE_CONT_EN defined: continuous mode per REQ-024 present.
REQ-030 Macro SPI_CORE_CONT_EN undefined: cont SHALL be ignored and every transfer ends per REQ-023.

Structure
REQ-031 Package spi_core_pkg SHALL hold the state typedef (IDLE, XFER) and the clk_div width constant.
REQ-032 A sub-module spi_clk_gen SHALL produce the N-clock toggle-event pulse; all else in spi_core.

Verification
REQ-033 D_WIDTH=8, clk_div=2, cpol=0, cpha=0, tx_data=0xA5, miso looped to mosi -> rx_data=0xA5, busy high 34 clocks, 8 sclk rising edges.
REQ-034 cpol=1, cpha=1, clk_div=0, tx_data=0x3C, miso tied 1 -> sclk idles high, busy high 17 clocks, rx_data=0xFF, mosi bit sequence 0,0,1,1,1,1,0,0.
REQ-035 cont=1, tx 0x12 then 0x34, loopback -> ss_n[0] low throughout, busy low one clock between words, rx_data 0x12 then 0x34.
REQ-036 reset_n pulsed low mid-transfer -> ss_n=1, busy=0, rx_data=0 same cycle; a new enable then completes normally.
REQ-037 enable held high continuously, cont=0 -> transfers repeat with ss_n high for at least one clock between words.
